// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the direct-mapped cache: line/word sizing, FSM states and
// a helper that derives the tag width from the index width.
package cache_types_pkg;

  localparam int unsigned AddrW    = 16;
  localparam int unsigned WordW    = 16;
  localparam int unsigned LineBits = 128;
  localparam int unsigned OffsetW  = 4;
  localparam int unsigned WordSelW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRespond,
    StWriteback,
    StFill
  } cache_state_e;

  function automatic int unsigned tag_width(int unsigned index_w);
    return AddrW - OffsetW - index_w;
  endfunction

endpackage

// File: rtl/cache_array.sv
// Per-line storage for the direct-mapped cache: valid/dirty bits (reset) plus tag and data
// arrays (not reset). Combinational read by index, synchronous line/word writes.
module cache_array
  import cache_types_pkg::*;
#(
  parameter int unsigned NumSets = 8,
  localparam int unsigned IndexW = $clog2(NumSets),
  localparam int unsigned TagW   = tag_width(IndexW)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IndexW-1:0]   index_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TagW-1:0]     tag_o,
  output logic [LineBits-1:0] line_o,
  input  logic                line_we_i,
  input  logic [TagW-1:0]     line_tag_i,
  input  logic [LineBits-1:0] line_wdata_i,
  input  logic                word_we_i,
  input  logic [WordSelW-1:0] word_sel_i,
  input  logic [WordW-1:0]    word_wdata_i,
  input  logic                set_dirty_i,
  input  logic                clr_dirty_i
);

  logic [NumSets-1:0]  valid_q;
  logic [NumSets-1:0]  dirty_q;
  logic [TagW-1:0]     tag_q  [NumSets];
  logic [LineBits-1:0] data_q [NumSets];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (set_dirty_i) begin
      dirty_q[index_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[index_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[index_i] <= line_wdata_i;
      tag_q[index_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[index_i][{word_sel_i, 4'h0} +: WordW] <= word_wdata_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between a 16-bit CPU port and a 128-bit
// line port. Holds the FSM, hit compare and byte merge; storage lives in cache_array.
module dm_cache
  import cache_types_pkg::*;
#(
  parameter int unsigned NumSets = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [AddrW-1:0]    mem_address_i,
  input  logic [WordW-1:0]    mem_wdata_i,
  input  logic [1:0]          mem_wmask_i,
  output logic                mem_resp_o,
  output logic [WordW-1:0]    mem_rdata_o,
  output logic                pmem_read_o,
  output logic                pmem_write_o,
  output logic [AddrW-1:0]    pmem_address_o,
  output logic [LineBits-1:0] pmem_wdata_o,
  input  logic                pmem_resp_i,
  input  logic [LineBits-1:0] pmem_rdata_i
);

  localparam int unsigned IndexW = $clog2(NumSets);
  localparam int unsigned TagW   = tag_width(IndexW);

  logic [IndexW-1:0]   index;
  logic [TagW-1:0]     req_tag;
  logic [WordSelW-1:0] word_sel;
  logic                unused_addr_lsb;

  assign word_sel        = mem_address_i[OffsetW-1:1];
  assign index           = mem_address_i[OffsetW+IndexW-1:OffsetW];
  assign req_tag         = mem_address_i[AddrW-1:OffsetW+IndexW];
  assign unused_addr_lsb = mem_address_i[0];

  logic                line_valid, line_dirty;
  logic [TagW-1:0]     line_tag;
  logic [LineBits-1:0] line_data;
  logic                line_we, word_we, set_dirty, clr_dirty;
  logic [WordW-1:0]    cur_word, merged_word;
  logic                req, hit;

  cache_array #(
    .NumSets(NumSets)
  ) u_array (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .index_i     (index),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_wdata_i(pmem_rdata_i),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_wdata_i(merged_word),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty)
  );

  assign req      = mem_read_i | mem_write_i;
  assign hit      = line_valid && (line_tag == req_tag);
  assign cur_word = line_data[{word_sel, 4'h0} +: WordW];

  always_comb begin
    merged_word[15:8] = mem_wmask_i[1] ? mem_wdata_i[15:8] : cur_word[15:8];
    merged_word[7:0]  = mem_wmask_i[0] ? mem_wdata_i[7:0]  : cur_word[7:0];
  end

  cache_state_e     state_q, state_d;
  logic [WordW-1:0] rdata_q, rdata_d;
  logic             pread_q, pread_d;
  logic             pwrite_q, pwrite_d;
  logic [AddrW-1:0] paddr_q, paddr_d;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    pread_d   = pread_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    line_we   = 1'b0;
    word_we   = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            // Write wins when both request lines are high.
            if (mem_write_i) begin
              word_we   = 1'b1;
              set_dirty = 1'b1;
            end else begin
              rdata_d = cur_word;
            end
            state_d = StRespond;
          end else if (line_valid && line_dirty) begin
            pwrite_d = 1'b1;
            paddr_d  = {line_tag, index, {OffsetW{1'b0}}};
            state_d  = StWriteback;
          end else begin
            pread_d = 1'b1;
            paddr_d = {req_tag, index, {OffsetW{1'b0}}};
            state_d = StFill;
          end
        end
      end
      StRespond: state_d = StIdle;
      StWriteback: begin
        if (pmem_resp_i) begin
          clr_dirty = 1'b1;
          pwrite_d  = 1'b0;
          pread_d   = 1'b1;
          paddr_d   = {req_tag, index, {OffsetW{1'b0}}};
          state_d   = StFill;
        end
      end
      StFill: begin
        if (pmem_resp_i) begin
          line_we = 1'b1;
          pread_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rdata_q  <= '0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
    end
  end

  assign mem_resp_o     = (state_q == StRespond);
  assign mem_rdata_o    = rdata_q;
  assign pmem_read_o    = pread_q;
  assign pmem_write_o   = pwrite_q;
  assign pmem_address_o = paddr_q;
  // The stored line is untouched during writeback, so it is stable until pmem_resp.
  assign pmem_wdata_o   = line_data;

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed plan plus randomized accesses, checked against
// a flat word-memory reference and a per-set hit/miss model with a random-latency memory.
module tb_dm_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address, mem_wdata;
  logic [1:0]   mem_wmask;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  always #5 clk = ~clk;

  dm_cache #(
    .NumSets(8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .mem_address_i (mem_address),
    .mem_wdata_i   (mem_wdata),
    .mem_wmask_i   (mem_wmask),
    .mem_resp_o    (mem_resp),
    .mem_rdata_o   (mem_rdata),
    .pmem_read_o   (pmem_read),
    .pmem_write_o  (pmem_write),
    .pmem_address_o(pmem_address),
    .pmem_wdata_o  (pmem_wdata),
    .pmem_resp_i   (pmem_resp),
    .pmem_rdata_i  (pmem_rdata)
  );

  logic [127:0] phys    [4096];
  logic [15:0]  ref_mem [32768];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [8:0]   m_tag   [8];

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_line(input logic [11:0] la);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = ref_mem[{la, 3'(k)}];
    return l;
  endfunction

  task automatic reload_ref();
    for (int l = 0; l < 4096; l++)
      for (int k = 0; k < 8; k++) ref_mem[{12'(l), 3'(k)}] = phys[l][16*k +: 16];
  endtask

  task automatic clear_model();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] wm, output logic [15:0] got);
    int unsigned set, cyc, wb_cyc, fill_cyc, dly, exp_lat;
    logic [8:0]   tg;
    bit           hit, exp_wb, done, busy;
    logic [15:0]  exp_rd, exp_wb_addr, w;
    logic [127:0] exp_wb_data;
    set         = 32'(addr[6:4]);
    tg          = addr[15:7];
    hit         = m_valid[set] && (m_tag[set] == tg);
    exp_wb      = !hit && m_valid[set] && m_dirty[set];
    exp_wb_addr = {m_tag[set], addr[6:4], 4'h0};
    exp_wb_data = ref_line(exp_wb_addr[15:4]);
    exp_rd      = ref_mem[addr[15:1]];
    got         = 16'h0;

    @(posedge clk); #1;
    check_eq("resp_one_cycle", mem_resp, 1'b0);
    mem_address = addr;
    mem_wdata   = wd;
    mem_wmask   = wm;
    mem_write   = wr;
    mem_read    = rd;
    done = 0; busy = 0; cyc = 0; wb_cyc = 0; fill_cyc = 0; dly = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      pmem_resp = 1'b0;
      check_eq("pmem_overlap", pmem_read & pmem_write, 1'b0);
      if (pmem_write) begin
        if (!busy) begin
          busy = 1;
          dly  = $urandom_range(0, 3);
          check_eq("wb_addr", pmem_address, exp_wb_addr);
          check_eq("wb_data", pmem_wdata, exp_wb_data);
        end
        wb_cyc++;
        if (dly == 0) begin
          phys[pmem_address[15:4]] = pmem_wdata;
          pmem_resp = 1'b1;
          busy = 0;
        end else dly--;
      end else if (pmem_read) begin
        if (!busy) begin
          busy = 1;
          dly  = $urandom_range(0, 3);
          check_eq("fill_addr", pmem_address, {addr[15:4], 4'h0});
        end
        fill_cyc++;
        if (dly == 0) begin
          pmem_rdata = phys[pmem_address[15:4]];
          pmem_resp  = 1'b1;
          busy = 0;
        end else dly--;
      end
      if (mem_resp) begin
        done = 1;
        got  = mem_rdata;
      end
    end
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    exp_lat = hit ? 1 : wb_cyc + fill_cyc + 2;
    check_eq("resp_seen", done, 1'b1);
    check_eq("latency", cyc, exp_lat);
    check_eq("fill_seen", fill_cyc != 0, !hit);
    check_eq("wb_seen", wb_cyc != 0, exp_wb);
    if (!wr) check_eq("rdata", got, exp_rd);

    m_valid[set] = 1'b1;
    m_tag[set]   = tg;
    if (!hit) m_dirty[set] = 1'b0;
    if (wr) begin
      w = ref_mem[addr[15:1]];
      if (wm[0]) w[7:0] = wd[7:0];
      if (wm[1]) w[15:8] = wd[15:8];
      ref_mem[addr[15:1]] = w;
      m_dirty[set] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] a;
    bit          seen;
    int unsigned op;

    for (int l = 0; l < 4096; l++)
      for (int k = 0; k < 8; k++) phys[l][16*k +: 16] = 16'((l << 12) + ((l >> 4) << 3) + k);
    reload_ref();
    clear_model();

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_wdata = '0; mem_wmask = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_resp", mem_resp, 1'b0);
    check_eq("rst_pmem_read", pmem_read, 1'b0);
    check_eq("rst_pmem_write", pmem_write, 1'b0);
    check_eq("rst_pmem_addr", pmem_address, 16'h0);
    check_eq("rst_mem_rdata", mem_rdata, 16'h0);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 16'h0012, 16'h0, 2'b00, got);
    check_eq("plan_fill_word", got, 16'h1001);
    access(1'b0, 1'b1, 16'h0014, 16'h0, 2'b00, got);
    check_eq("plan_hit_word", got, 16'h1002);
    access(1'b1, 1'b0, 16'h0012, 16'hBEEF, 2'b01, got);
    access(1'b0, 1'b1, 16'h0012, 16'h0, 2'b00, got);
    check_eq("plan_merged", got, 16'h10EF);
    access(1'b0, 1'b1, 16'h0092, 16'h0, 2'b00, got);
    check_eq("plan_evict_fill", got, 16'h9001);
    access(1'b0, 1'b1, 16'h0012, 16'h0, 2'b00, got);
    check_eq("plan_refill", got, 16'h10EF);

    // Reset in the middle of a fill; a late pmem_resp must be ignored.
    @(posedge clk); #1;
    mem_address = 16'h0034;
    mem_read    = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = pmem_read;
    end
    check_eq("mid_fill_started", seen, 1'b1);
    rst_n      = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = '1;
    @(posedge clk); #1;
    check_eq("mid_rst_pmem_read", pmem_read, 1'b0);
    check_eq("mid_rst_pmem_write", pmem_write, 1'b0);
    check_eq("mid_rst_mem_resp", mem_resp, 1'b0);
    mem_read = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    check_eq("late_resp_pmem_read", pmem_read, 1'b0);
    check_eq("late_resp_mem_resp", mem_resp, 1'b0);
    clear_model();
    reload_ref();
    access(1'b0, 1'b1, 16'h0092, 16'h0, 2'b00, got);
    check_eq("post_rst_miss", got, 16'h9001);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      a  = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1))};
      access(op == 1 || op == 2, op != 1, a, 16'($urandom), 2'($urandom), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped, write-back, write-allocate cache. It is the responder on the CPU's 16-bit mem_* (or instr_*) port and the initiator on the 128-bit pmem_* line port toward physical memory.
- It sits between the mp3 pipeline and physical_memory, and replaces the magic memory in cached builds.
- One instance is used per CPU port.

Parameters:
- NUM_SETS, 8, number of lines. Must be a power of two, at least 2. INDEX_W = log2(NUM_SETS).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_address  in  16  CPU byte address; bit 0 ignored (word access)
- mem_wdata  in  16  CPU write data
- mem_wmask  in  2  byte enables; bit 1 = high byte
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data, valid while mem_resp=1
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  16  line address, bits [3:0] always 0
- pmem_wdata  out  128  writeback line
- pmem_resp  in  1  physical memory completion
- pmem_rdata  in  128  fill line, valid with pmem_resp

Behaviour:
- Address split:
  - offset = [3:0]; word select = [3:1]
  - index = [3+INDEX_W:4]
  - tag = [15:4+INDEX_W]; 9 bits at default
- Per-line state: valid, dirty, tag, 128-bit data.
- Reset (rst_n sampled low at a clock edge):
  - FSM goes to IDLE.
  - All valid and dirty bits clear. Data and tag arrays are not reset.
  - mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, mem_rdata=0.
- Reset mid-operation: any pmem transaction is abandoned. pmem_read and pmem_write are low from that edge onward, and a late pmem_resp is ignored.
- Request = mem_read | mem_write. If both are high, it is treated as a write.
- FSM states:
  - IDLE, no request: stay in IDLE.
  - IDLE, request and hit (valid & tag match):
    - Read: latch the selected word into mem_rdata.
    - Write: merge mem_wdata into the selected word per mem_wmask and set dirty. mem_wmask=00 still responds and still sets dirty.
    - Go to RESPOND.
  - IDLE, request and miss:
    - dirty → WRITEBACK
    - clean or invalid → FILL
  - RESPOND: mem_resp=1 for exactly this cycle, then IDLE. Responses are never back-to-back.
  - WRITEBACK:
    - pmem_write=1, pmem_address={old_tag, index, 4'h0}, pmem_wdata = stored line.
    - All three are held stable until pmem_resp.
    - On pmem_resp: clear dirty, go to FILL.
  - FILL:
    - pmem_read=1, pmem_address={req_tag, index, 4'h0}, held until pmem_resp.
    - On pmem_resp: write pmem_rdata into the line, set tag, valid=1, dirty=0, go to IDLE.
    - IDLE then re-evaluates the request, which now hits.
- Latency from request visible in IDLE to mem_resp:
  - hit: 1 cycle
  - clean miss: fill cycles + 2
  - dirty miss: writeback cycles + fill cycles + 2
- pmem_read and pmem_write are never high together. Each is registered and drops in the cycle after pmem_resp.
- pmem_resp outside WRITEBACK/FILL is ignored.
- The initiator must hold address, data and mask stable until mem_resp. A request change mid-miss is unsupported; the cache serves the address present in IDLE.
- Word order in a line: word k occupies bits [16k+15:16k]. Byte 0 is the low byte of a word.

Decomposition:
- Shared package cache_types_pkg:
  - LINE_BITS=128, OFFSET_W=4, WORD_SEL_W=3
  - state enum (IDLE, RESPOND, WRITEBACK, FILL)
  - helper for tag width from INDEX_W
- One sub-module, cache_array:
  - parameterised on NUM_SETS
  - holds valid/dirty/tag/data
  - combinational read by index; synchronous write with line-write, word-merge, set-dirty and clear-dirty controls
  - valid/dirty cleared on rst_n
- The FSM, hit compare and merge logic live in dm_cache.

Test Plan:
- After reset, read 0x0012 → one FILL with pmem_address=0x0010. Memory returns a line with word k = 0x1000+k. mem_rdata=0x1001, mem_resp exactly one cycle, total latency = fill + 2.
- Then read 0x0014 → hit, mem_resp one cycle after request, mem_rdata=0x1002, no pmem activity.
- Write 0x0012 with wdata=0xBEEF, wmask=01 → hit. Subsequent read returns 0x10EF; line is now dirty.
- Read 0x0092 (same index 1, tag 1) → WRITEBACK to 0x0010 with pmem_wdata word 1 = 0x10EF, then FILL from 0x0090. pmem_read and pmem_write never overlap.
- Read 0x0012 again → clean miss: no writeback, fill only. Returns the memory's updated 0x10EF.
- Assert rst_n=0 during FILL (pmem_read high) → pmem_read low at that edge and no mem_resp. The following read of 0x0092 misses (valid cleared).
